// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: MDOp codes, FSM states and cycle defaults.
// The decoder and hazard unit import the same MDOp constants.
package md_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMthi  = 4'd5,
        MdMtlo  = 4'd6,
        MdMfhi  = 4'd7,
        MdMflo  = 4'd8
    } md_op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned MultCyclesDefault = 5;
    localparam int unsigned DivCyclesDefault  = 10;

    function automatic logic is_mul(input md_op_e op);
        return (op == MdMult) || (op == MdMultu);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath producing the pending HI/LO pair.
// Divide by zero, and any non-mult/div op, returns the current HI/LO unchanged.
module e_mdu_calc
    import md_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] ph_o,
    output logic [31:0] pl_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] q_s;
    logic        [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'b0, a_i} * {32'b0, b_i};

        // Signed divide via magnitudes: truncates toward zero, remainder takes
        // the dividend's sign, and 0x80000000 / -1 wraps back to 0x80000000.
        a_mag = a_i[31] ? (32'd0 - a_i) : a_i;
        b_mag = b_i[31] ? (32'd0 - b_i) : b_i;
        q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        q_s   = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = a_i[31] ? (32'd0 - r_mag) : r_mag;
        q_u   = (b_i == 32'd0) ? 32'd0 : a_i / b_i;
        r_u   = (b_i == 32'd0) ? 32'd0 : a_i % b_i;

        ph_o = hi_i;
        pl_o = lo_i;
        case (op_i)
            MdMult: begin
                ph_o = prod_s[63:32];
                pl_o = prod_s[31:0];
            end
            MdMultu: begin
                ph_o = prod_u[63:32];
                pl_o = prod_u[31:0];
            end
            MdDiv: begin
                if (b_i != 32'd0) begin
                    ph_o = r_s;
                    pl_o = q_s;
                end
            end
            MdDivu: begin
                if (b_i != 32'd0) begin
                    ph_o = r_u;
                    pl_o = q_u;
                end
            end
            default: begin
                ph_o = hi_i;
                pl_o = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// countdown and drives Busy for the hazard unit.
module e_mdu
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] HILO_out
);

    localparam int unsigned CntMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    md_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] ph_q, ph_d;
    logic [31:0] pl_q, pl_d;
    logic [31:0] calc_ph;
    logic [31:0] calc_pl;
    md_op_e      op;

    assign op = md_op_e'(MDOp);

    e_mdu_calc u_calc (
        .op_i (op),
        .a_i  (A),
        .b_i  (B),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .ph_o (calc_ph),
        .pl_o (calc_pl)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        unique case (state_q)
            StIdle: begin
                if (!Req) begin
                    if (Start && (is_mul(op) || is_div(op))) begin
                        state_d = StRun;
                        cnt_d   = is_mul(op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                        ph_d    = calc_ph;
                        pl_d    = calc_pl;
                    end else if (op == MdMthi) begin
                        hi_d = A;
                    end else if (op == MdMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                // Req does not cancel: the owning instruction has already left E.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = ph_q;
                    lo_d    = pl_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Busy     = (state_q == StRun);
        HI_out   = hi_q;
        LO_out   = lo_q;
        HILO_out = (op == MdMfhi) ? hi_q : lo_q;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the P7 pipeline; runs in parallel with the ALU.
- Owns the architectural HI/LO registers and the Busy stall source.
- Its read result for mfhi/mflo is what the E→M pipeline register captures as HILO_in.
- Multi-cycle mult/div are modelled with a fixed-latency counter, and exception flush (Req) is honoured.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  1  exception/interrupt request; the instruction currently in E is cancelled.
- Start  in  1  E-stage instruction is mult/multu/div/divu, valid this cycle.
- MDOp  in  4  operation code (see package).
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- Busy  out  1  multi-cycle operation in progress.
- HI_out  out  32  current HI register.
- LO_out  out  32  current LO register.
- HILO_out  out  32  HI_out when MDOp==MFHI, otherwise LO_out; combinational.

Behaviour:
- Reset: on Rst at posedge, HI=0, LO=0, Busy=0, counter=0, FSM=IDLE, pending results=0. This aborts any in-flight operation; no HI/LO write occurs.
- FSM states: IDLE, RUN.
- IDLE→RUN: at posedge with Start=1, Req=0, and MDOp in {MULT, MULTU, DIV, DIVU}.
  - A and B are latched.
  - Full result is computed into pending registers PH/PL.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from the next cycle.
- RUN: counter decrements every cycle. At the posedge where counter==1: HI<=PH, LO<=PL, counter->0, FSM->IDLE.
- Busy timing: high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). The new HI/LO are visible in the first cycle Busy is low again.
- Stall contract: the hazard unit stalls any md-class instruction in E while (Start|Busy). The block therefore never sees Start during RUN. If it does, Start is ignored; this case is a verification assertion.
- MTHI/MTLO:
  - Single-cycle. When MDOp==MTHI (or MTLO), Req=0 and FSM=IDLE, HI (or LO) <= A at the posedge.
  - Ignored while RUN; the stall contract prevents it.
- Req=1:
  - Start is ignored, and MTHI/MTLO writes are suppressed in that cycle.
  - An operation already in RUN is NOT cancelled, because its instruction has already left E. It completes and commits normally.
- MULT: signed 64-bit product, {HI,LO}=A*B.
- MULTU: unsigned 64-bit product.
- DIV: signed.
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B==0): counter runs and Busy behaves normally, but HI/LO stay unchanged at commit (PH/PL loaded with the current HI/LO).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MFHI/MFLO/NONE: no state change. HILO_out reflects the register contents as of that cycle. There is no internal bypass of in-flight results; mf* is stalled by Busy.
- Simultaneous Rst and Start: Rst wins.
- Operation at commit edge: a new Start arriving at the same edge as a commit is impossible under the stall contract. If it occurs it is ignored.

Decomposition:
- Package md_pkg holds:
  - the MDOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8;
  - the state encodings IDLE and RUN;
  - default cycle constants.
- The decoder and hazard unit import the same MDOp constants.
- One natural sub-module: e_mdu_calc. It is purely combinational: given op, A, B, HI and LO, it returns PH and PL, including the signed/unsigned, div-by-zero and overflow rules. e_mdu keeps the FSM, counter and registers.

Test Plan:
- MULT A=0xFFFFFFFE(-2), B=3 with Start for 1 cycle → Busy high 5 cycles; after that HI=0xFFFFFFFF, LO=0xFFFFFFFA; HILO_out=LO with MDOp=MFLO.
- DIV A=0xFFFFFFF9(-7), B=2 → Busy 10 cycles; then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
- MTHI A=0x12345678 then MFHI next cycle → HI_out=HILO_out=0x12345678, Busy never asserted. Repeat with Req=1 in the MTHI cycle → HI unchanged.
- Start MULTU A=0xFFFFFFFF, B=0xFFFFFFFF with Req=1 → Busy stays 0 and HI/LO unchanged. Start without Req, then pulse Req in cycle 2 of RUN → commit still gives HI=0xFFFFFFFE, LO=0x00000001.
- DIV with B=0 and preloaded HI=0xAA, LO=0xBB → Busy 10 cycles, HI/LO remain 0xAA/0xBB. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIV, assert Rst in cycle 4 of RUN → next cycle Busy=0, HI=LO=0, and no later commit occurs.
